// File: rtl/synth_pkg.sv
// Shared constants, event encoding and the equal-temperament frequency table
// for the 48-key keyboard synth.
package synth_pkg;

  localparam int NUM_KEYS   = 48;
  localparam int KEY_W      = 6;
  localparam int MIN_VOICES = 2;
  localparam int MAX_VOICES = 8;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_ON,
    EV_OFF
  } key_event_e;

  // Integer Hz, truncated; key 0 = C3, key 47 = B6.
  function automatic logic [31:0] key_freq(input logic [KEY_W-1:0] idx);
    case (idx)
      6'd0:  key_freq = 32'd130;
      6'd1:  key_freq = 32'd138;
      6'd2:  key_freq = 32'd146;
      6'd3:  key_freq = 32'd155;
      6'd4:  key_freq = 32'd164;
      6'd5:  key_freq = 32'd174;
      6'd6:  key_freq = 32'd184;
      6'd7:  key_freq = 32'd195;
      6'd8:  key_freq = 32'd207;
      6'd9:  key_freq = 32'd220;
      6'd10: key_freq = 32'd233;
      6'd11: key_freq = 32'd246;
      6'd12: key_freq = 32'd261;
      6'd13: key_freq = 32'd277;
      6'd14: key_freq = 32'd293;
      6'd15: key_freq = 32'd311;
      6'd16: key_freq = 32'd329;
      6'd17: key_freq = 32'd349;
      6'd18: key_freq = 32'd369;
      6'd19: key_freq = 32'd391;
      6'd20: key_freq = 32'd415;
      6'd21: key_freq = 32'd440;
      6'd22: key_freq = 32'd466;
      6'd23: key_freq = 32'd493;
      6'd24: key_freq = 32'd523;
      6'd25: key_freq = 32'd554;
      6'd26: key_freq = 32'd587;
      6'd27: key_freq = 32'd622;
      6'd28: key_freq = 32'd659;
      6'd29: key_freq = 32'd698;
      6'd30: key_freq = 32'd739;
      6'd31: key_freq = 32'd783;
      6'd32: key_freq = 32'd830;
      6'd33: key_freq = 32'd880;
      6'd34: key_freq = 32'd932;
      6'd35: key_freq = 32'd987;
      6'd36: key_freq = 32'd1046;
      6'd37: key_freq = 32'd1108;
      6'd38: key_freq = 32'd1174;
      6'd39: key_freq = 32'd1244;
      6'd40: key_freq = 32'd1318;
      6'd41: key_freq = 32'd1396;
      6'd42: key_freq = 32'd1479;
      6'd43: key_freq = 32'd1567;
      6'd44: key_freq = 32'd1661;
      6'd45: key_freq = 32'd1760;
      6'd46: key_freq = 32'd1864;
      6'd47: key_freq = 32'd1975;
      default: key_freq = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/free_voice_finder.sv
// Lowest-index priority encoder over the idle voices.
module free_voice_finder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] gate,
  output logic         any_free,
  output logic [W-1:0] free_idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    any_free = 1'b0;
    free_idx = '0;
    // Descending scan: the last match written is the lowest index.
    for (int v = N - 1; v >= 0; v--) begin
      if (!gate[v]) begin
        any_free = 1'b1;
        free_idx = W'(v);
      end
    end
  end

endmodule

// File: rtl/note_voice_allocator.sv
// Scans one key per clock, detects note-on/off against held[], and assigns
// keys to tone-generator voices, stealing round-robin when all are busy.
module note_voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES*32-1:0]    voice_freq,
  output logic [NUM_VOICES-1:0]       voice_load,
  output logic [KEY_W-1:0]            scan_idx
);

  localparam int PTR_W = $clog2(NUM_VOICES);

  logic [NUM_KEYS-1:0] held;
  logic [PTR_W-1:0]    steal_ptr;
  logic                any_free;
  logic [PTR_W-1:0]    free_idx;
  logic [PTR_W-1:0]    target;
  key_event_e          ev;

  free_voice_finder #(
    .N (NUM_VOICES),
    .W (PTR_W)
  ) u_free_voice_finder (
    .gate     (voice_gate),
    .any_free (any_free),
    .free_idx (free_idx)
  );

  always_comb begin
    ev = EV_NONE;
    if (key[scan_idx] && !held[scan_idx]) begin
      ev = EV_ON;
    end else if (!key[scan_idx] && held[scan_idx]) begin
      ev = EV_OFF;
    end
    target = any_free ? free_idx : steal_ptr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx   <= '0;
      held       <= '0;
      steal_ptr  <= '0;
      voice_gate <= '0;
      voice_key  <= '0;
      voice_freq <= '0;
      voice_load <= '0;
    end else begin
      scan_idx   <= (scan_idx == KEY_W'(NUM_KEYS - 1)) ? '0 : scan_idx + 1'b1;
      voice_load <= '0;

      if (ev == EV_ON) begin
        held[scan_idx] <= 1'b1;
        if (!any_free) begin
          steal_ptr <= (steal_ptr == PTR_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
        end
      end else if (ev == EV_OFF) begin
        held[scan_idx] <= 1'b0;
      end

      for (int v = 0; v < NUM_VOICES; v++) begin
        if (ev == EV_ON && target == PTR_W'(v)) begin
          voice_gate[v]                 <= 1'b1;
          voice_key[v*KEY_W +: KEY_W]   <= scan_idx;
          voice_freq[v*32 +: 32]        <= key_freq(scan_idx);
          voice_load[v]                 <= 1'b1;
        end
        // A stolen key matches no voice, so its release only clears held[].
        if (ev == EV_OFF && voice_gate[v] && voice_key[v*KEY_W +: KEY_W] == scan_idx) begin
          voice_gate[v] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/note_voice_allocator.md
Name: note_voice_allocator

Overview:
- Polyphonic voice scheduler for the 48-key keyboard synth.
- Scans the 48 debounced key levels one key per clock and detects note-on and note-off events.
- Assigns each pressed key to one of NUM_VOICES tone-generator voices and steals a voice when all are busy.
- Per voice, presents the key index, the looked-up frequency in Hz and a gate; the tone generators consume these directly.

Parameters:
- NUM_KEYS, 48, number of key inputs; key 0 = C3 and key 47 = B6, chromatic.
- NUM_VOICES, 4, number of tone-generator voices; legal range 2..8.
- KEY_W, 6, width of a key index.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- key  input  NUM_KEYS  debounced, clk-synchronous key levels; 1 = pressed
- voice_gate  output  NUM_VOICES  1 = voice v is sounding
- voice_key  output  NUM_VOICES*KEY_W  key index of voice v, in slice [v*KEY_W +: KEY_W]
- voice_freq  output  NUM_VOICES*32  frequency in Hz for voice v, in slice [v*32 +: 32]
- voice_load  output  NUM_VOICES  one-cycle pulse when voice v takes a new key; phase-reset strobe
- scan_idx  output  KEY_W  key index being examined this cycle; for debug and the bench

Behaviour:
- Reset (async, active-high):
  - voice_gate, voice_key, voice_freq, voice_load are all 0.
  - scan_idx = 0, held[] = 0, steal_ptr = 0.
- Scanner:
  - scan_idx increments every cycle and wraps from 47 to 0.
  - Exactly one key is evaluated per cycle, so the scan period is 48 cycles.
  - Worst-case event latency is 48 cycles; events are registered, and outputs update on the clock edge that ends the evaluation cycle.
- Internal state:
  - held[NUM_KEYS]: key has been accepted as pressed.
  - owner[v]: voice v holds a key, given by voice_gate[v] and voice_key[v].
- Evaluation of key i = scan_idx; exactly one case applies:
  - key[i]=1 and held[i]=0, note-on:
    - Set held[i].
    - If some gate is 0, take the lowest-index free voice f: gate[f]=1, key[f]=i, freq[f]=FREQ(i), load[f]=1.
    - Otherwise steal voice steal_ptr: key and freq overwritten, gate stays 1, load=1. Then steal_ptr increments, wrapping at NUM_VOICES-1.
  - key[i]=0 and held[i]=1, note-off:
    - Clear held[i].
    - For any voice with gate=1 and key=i, clear gate; key and freq hold their last values.
    - If no voice matches (the key was stolen), only held[i] is cleared.
  - key[i]=held[i]: no action.
- Stolen keys keep held=1, so they are never reassigned until released and pressed again.
- A key toggling and settling between two visits to its index is invisible; this is intended.
- A key is never assigned to two voices: held[] blocks a repeat note-on.
- voice_load is 0 in every cycle without an assignment, and at most one bit is set per cycle.
- steal_ptr moves only on a steal, never on a free-voice assignment or a release.
- voice_freq is registered and valid in the same cycle that voice_gate and voice_load assert.

Decomposition:
- Shared package synth_pkg:
  - NUM_KEYS = 48, KEY_W = 6.
  - Function key_freq(idx): equal-temperament table, integer Hz truncated, 130,138,146,...,440 (idx 21),...,1975 (idx 47); returns 0 for idx ≥ 48.
  - Voice-count limit constant.
- One sub-module, free_voice_finder: combinational lowest-index priority encoder over ~voice_gate, with outputs any_free and free_idx.

Test Plan:
- Reset mid-operation: 3 voices active, rst pulsed asynchronously mid-cycle -> all outputs 0 immediately; scan_idx=0 after release; keys still held are re-detected as note-ons within 48 cycles.
- Single note: hold key[21] -> within ≤48 cycles voice 0 shows gate=1, key=21, freq=440, and a 1-cycle load[0]. Release -> gate[0]=0 within ≤48 cycles; key[0]=21 and freq=440 retained.
- Fill and steal: hold keys 0,12,24,36 and then key 47 -> voices 0..3 get 130, 261, 523, 1046 in scan order. Key 47 then steals voice 0 (freq=1975, load[0]=1), steal_ptr=1. Adding key 45 next steals voice 1 (freq=1760).
- Stolen release: release key 0 after it was stolen -> no gate or load change, held[0] cleared. Re-press key 0 -> steals voice steal_ptr.
- Free reuse: with 4 voices busy, release key 24 (voice 2), then press key 9 -> voice 2 gets freq=220, steal_ptr unchanged.
- Glitch filter: pulse key[5] high for 1 cycle while scan_idx≠5 -> no assignment and no load pulse.
